// File: rtl/fetch_queue_pkg.sv
// Shared types and helpers for the fetch queue: the stored entry layout and
// the rule that turns a fetched doubleword into an entry.
package fetch_queue_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    typedef struct packed {
        logic [PC_W-1:0]      pc;         // PC of slot 0
        logic [2*INSTR_W-1:0] instr;      // [31:0] slot 0, [63:32] slot 1
        logic [1:0]           slot_v;     // per-slot valid
        logic                 prd_taken;  // prediction carried with the pair
    } fetch_entry_t;

    // A fetch to the upper word of a doubleword yields only one useful
    // instruction; it is moved into slot 0 and slot 1 is marked invalid.
    function automatic fetch_entry_t build_entry(
        input logic [PC_W-1:0]      pc,
        input logic                 prd_taken,
        input logic [2*INSTR_W-1:0] rdata
    );
        fetch_entry_t e;
        e.pc        = pc;
        e.prd_taken = prd_taken;
        if (pc[2]) begin
            e.instr  = {{INSTR_W{1'b0}}, rdata[2*INSTR_W-1:INSTR_W]};
            e.slot_v = 2'b01;
        end else begin
            e.instr  = rdata;
            e.slot_v = 2'b11;
        end
        return e;
    endfunction

endpackage

// File: rtl/fetch_fifo_mem.sv
// Entry storage for the fetch queue: one synchronous write port and one
// combinational read port. Occupancy tracking lives in the parent.
module fetch_fifo_mem
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  fetch_entry_t     i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output fetch_entry_t     o_rdata
);

    fetch_entry_t r_mem [DEPTH];

    // Write the captured pair into the addressed slot.
    // NOTE: the array has no reset; an entry is only ever read after the
    // count says it was written, so clearing it would buy nothing.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-side instruction queue: records each IMEM request, captures the
// returned doubleword one cycle later, buffers pairs for 2-wide decode and
// throttles the next-PC stage so no returning pair is ever dropped.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [PC_W-1:0]    i_fetch_pc,
    input  logic               i_prd_taken,
    input  logic               i_br_miss_n,
    output logic               o_fetch_en,
    input  logic [2*INSTR_W-1:0] i_imem_rdata,
    output logic               o_dec_valid,
    input  logic               i_dec_ready,
    output logic [PC_W-1:0]    o_dec_pc,
    output logic [2*INSTR_W-1:0] o_dec_instr,
    output logic [1:0]         o_dec_slot_v,
    output logic               o_dec_prd_taken,
    output logic [PTR_W:0]     o_count
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic             r_inflight_v;
    logic [PC_W-1:0]  r_inflight_pc;
    logic             r_inflight_prd;

    logic             w_flush;
    logic             w_pop;
    logic             w_capture;
    logic             w_mem_we;
    logic [PTR_W:0]   w_occupancy;
    fetch_entry_t     w_wr_entry;
    fetch_entry_t     w_head;

    assign w_flush     = ~i_br_miss_n;
    assign o_dec_valid = (r_count != '0);
    assign w_pop       = o_dec_valid & i_dec_ready;
    assign w_capture   = r_inflight_v;

    // Entries held after this edge if nothing is flushed: stored pairs plus
    // the pair arriving now, minus the one decode takes. Also the next count.
    assign w_occupancy = r_count
                       + {{PTR_W{1'b0}}, r_inflight_v}
                       - {{PTR_W{1'b0}}, w_pop};

    // A write that coincides with reset or flush belongs to the wrong path.
    assign w_mem_we   = w_capture & ~w_flush & ~i_rst;
    assign w_wr_entry = build_entry(r_inflight_pc, r_inflight_prd, i_imem_rdata);

    // Allow a new request only if its pair is guaranteed a slot; a flush
    // always enables so the PC register loads the redirect target.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        o_fetch_en = 1'b0;
        if (!i_rst) begin
            if (w_flush) begin
                o_fetch_en = 1'b1;
            end else begin
                o_fetch_en = (w_occupancy < DEPTH_C);
            end
        end
    end

    // Pointer and occupancy bookkeeping; reset and flush both empty the queue.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking so every register here samples pre-edge values.
        if (i_rst || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_capture) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_occupancy;
        end
    end

    // Remember the request presented to IMEM this cycle; no request is
    // recorded while flushing because that PC is on the wrong path.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inflight_v <= 1'b0;
        end else begin
            r_inflight_v <= o_fetch_en & i_br_miss_n;
        end
        if (o_fetch_en) begin
            r_inflight_pc  <= i_fetch_pc;
            r_inflight_prd <= i_prd_taken;
        end
    end

    fetch_fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_entry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    assign o_dec_pc        = w_head.pc;
    assign o_dec_instr     = w_head.instr;
    assign o_dec_prd_taken = w_head.prd_taken;
    assign o_dec_slot_v    = o_dec_valid ? w_head.slot_v : 2'b00;
    assign o_count         = r_count;

    a_count_bound : assert property (@(posedge i_clk) disable iff (i_rst)
        r_count <= DEPTH_C);

    a_no_overflow : assert property (@(posedge i_clk) disable iff (i_rst || w_flush)
        !(w_capture && (r_count == DEPTH_C) && !w_pop));

endmodule
